// File: rtl/progressive_div_pkg.sv
// -----------------------------------------------------------------------------
// progressive_div_pkg
// Shared widths, FSM state type and saturation helpers for the progressive
// Q2.14 / Q1.x divider (progressive_div16) and its step unit.
// -----------------------------------------------------------------------------
package progressive_div_pkg;

  localparam int Q_W   = 16;  // full quotient width (Q1.14 + integer bit)
  localparam int R_W   = 17;  // partial remainder width
  localparam int Q12_W = 4;   // Q1.2 output width
  localparam int Q16_W = 8;   // Q1.6 output width

  // Quotient value used whenever the true result would not fit in 16 bits.
  localparam logic [Q_W-1:0] SAT_Q = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    SAT  = 2'd2
  } div_state_e;

  // Quotient >= 2^16 exactly when b == 0 or a >= 4*b (compared in 18 bits).
  function automatic logic sat_cond(input logic [Q_W-1:0] a_v,
                                    input logic [Q_W-1:0] b_v);
    return (b_v == '0) || ({2'b00, a_v} >= {b_v, 2'b00});
  endfunction

endpackage

// File: rtl/progressive_div16_step.sv
// -----------------------------------------------------------------------------
// div_step_unit
// One restoring-division step: shift the partial remainder left, bring in the
// next dividend bit, subtract the divisor when it fits.
// Ports:
//   r_i  partial remainder in      b_i  divisor
//   n_i  next dividend bit         r_o  partial remainder out
//   q_o  resolved quotient bit
// -----------------------------------------------------------------------------
module div_step_unit
  import progressive_div_pkg::*;
(
  input  logic [R_W-1:0] r_i,
  input  logic [Q_W-1:0] b_i,
  input  logic           n_i,
  output logic [R_W-1:0] r_o,
  output logic           q_o
);

  logic [R_W-1:0] r_sh;

  assign r_sh = {r_i[R_W-2:0], n_i};

  // If the bit shifted out of r_i was set, the shifted value is >= 2^17 and
  // therefore larger than any divisor. The 17-bit difference stays exact
  // because the true result is always below b.
  assign q_o = r_i[R_W-1] | (r_sh >= {1'b0, b_i});
  assign r_o = q_o ? (r_sh - {1'b0, b_i}) : r_sh;

endmodule

// File: rtl/progressive_div16.sv
// -----------------------------------------------------------------------------
// progressive_div16
// Unsigned Q2.14 / Q2.14 restoring divider, MSB first, BITS_PER_CYCLE quotient
// bits per cycle. Delivers Q1.2, Q1.6 and Q1.14 results as they resolve.
// Optional build macro: PROGRESSIVE_DIV_ROUND_EN (one guard bit, round the
// Q1.14 result, which then arrives one cycle later).
// Ports:
//   clk, rst (sync, active high)
//   a, b, valid_in, in_ready     request side (transfer on valid_in && in_ready)
//   q1_2_out/q1_2_valid, q1_6_out/q1_6_valid, q1_14_out/q1_14_valid
//   div_by_zero                  qualified by q1_14_valid
// Handshake: a request is taken on any clock where valid_in && in_ready;
// in_ready is low while a division iterates; outputs have no backpressure and
// each valid is a one-cycle pulse with data held until the next pulse.
// -----------------------------------------------------------------------------
module progressive_div16
  import progressive_div_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Q_W-1:0]   a,
  input  logic [Q_W-1:0]   b,
  input  logic             valid_in,
  output logic             in_ready,
  output logic [Q12_W-1:0] q1_2_out,
  output logic             q1_2_valid,
  output logic [Q16_W-1:0] q1_6_out,
  output logic             q1_6_valid,
  output logic [Q_W-1:0]   q1_14_out,
  output logic             q1_14_valid,
  output logic             div_by_zero
);

  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4))
  begin : g_bad_bits_per_cycle
    $error("progressive_div16: BITS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [4:0] STEP = 5'(BITS_PER_CYCLE);
`ifdef PROGRESSIVE_DIV_ROUND_EN
  // The guard-bit cycle runs after all 16 quotient bits are resolved.
  localparam logic [4:0] LAST_DONE = 5'd16;
`else
  localparam logic [4:0] LAST_DONE = 5'(16 - BITS_PER_CYCLE);
`endif

  div_state_e state_q, state_d;

  logic [R_W-1:0]   r_q,    r_d;
  logic [Q_W-1:0]   b_q,    b_d;
  logic [1:0]       nlo_q,  nlo_d;   // a[1:0], fed in as the first two bits
  logic [4:0]       done_q, done_d;  // quotient bits resolved so far
  logic [Q_W-1:0]   acc_q,  acc_d;   // quotient bits, shifted in at the LSB
  logic [Q12_W-1:0] q12_q,  q12_d;
  logic [Q16_W-1:0] q16_q,  q16_d;
  logic [Q_W-1:0]   q114_q, q114_d;
  logic             q12_v_q, q12_v_d;
  logic             q16_v_q, q16_v_d;
  logic             q114_v_q, q114_v_d;
  logic             dbz_q,  dbz_d;

  // ---------------------------------------------------------------------------
  // Step-unit chain
  // ---------------------------------------------------------------------------
  logic [BITS_PER_CYCLE:0][R_W-1:0] r_chain;
  logic [BITS_PER_CYCLE-1:0]        qb;      // qb[B-1] is the earliest bit
  logic [Q_W-1:0]                   acc_next;
  logic [4:0]                       done_nx;

  assign r_chain[0] = r_q;

  for (genvar j = 0; j < BITS_PER_CYCLE; j++) begin : g_step
    logic [4:0] pos;
    logic       n_bit;

    assign pos   = done_q + 5'(j);
    assign n_bit = (pos == 5'd0) ? nlo_q[1] :
                   (pos == 5'd1) ? nlo_q[0] : 1'b0;

    div_step_unit u_step (
      .r_i (r_chain[j]),
      .b_i (b_q),
      .n_i (n_bit),
      .r_o (r_chain[j+1]),
      .q_o (qb[BITS_PER_CYCLE-1-j])
    );
  end

  assign acc_next = (acc_q << BITS_PER_CYCLE) | Q_W'(qb);
  assign done_nx  = done_q + STEP;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. SAT is the cycle the saturated result is shown; it
  // accepts a new request just like IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, SAT: begin
        if (valid_in) state_d = sat_cond(a, b) ? SAT : ITER;
        else          state_d = IDLE;
      end
      ITER: begin
        if (done_q == LAST_DONE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready = (state_q != ITER);
    r_d      = r_q;
    b_d      = b_q;
    nlo_d    = nlo_q;
    done_d   = done_q;
    acc_d    = acc_q;
    q12_d    = q12_q;
    q16_d    = q16_q;
    q114_d   = q114_q;
    dbz_d    = dbz_q;
    q12_v_d  = 1'b0;
    q16_v_d  = 1'b0;
    q114_v_d = 1'b0;

    case (state_q)
      IDLE, SAT: begin
        if (valid_in) begin
          b_d    = b;
          nlo_d  = a[1:0];
          r_d    = {3'b000, a[Q_W-1:2]};  // a >> 2, always < b when not saturated
          done_d = '0;
          acc_d  = '0;
          if (sat_cond(a, b)) begin
            q12_d    = SAT_Q[Q_W-1 -: Q12_W];
            q16_d    = SAT_Q[Q_W-1 -: Q16_W];
            q114_d   = SAT_Q;
            q12_v_d  = 1'b1;
            q16_v_d  = 1'b1;
            q114_v_d = 1'b1;
            dbz_d    = (b == '0);
          end
        end
      end

      ITER: begin
        r_d    = r_chain[BITS_PER_CYCLE];
        acc_d  = acc_next;
        done_d = done_nx;
`ifdef PROGRESSIVE_DIV_ROUND_EN
        if (done_q == 5'd16) begin
          // Guard cycle: only the first step's bit (bit -1) is meaningful.
          acc_d    = acc_q;
          q114_d   = (&acc_q) ? SAT_Q : acc_q + Q_W'(qb[BITS_PER_CYCLE-1]);
          q114_v_d = 1'b1;
          dbz_d    = 1'b0;
        end else begin
          if (done_nx == 5'd4) begin
            q12_d   = acc_next[Q12_W-1:0];
            q12_v_d = 1'b1;
          end
          if (done_nx == 5'd8) begin
            q16_d   = acc_next[Q16_W-1:0];
            q16_v_d = 1'b1;
          end
        end
`else
        if (done_nx == 5'd4) begin
          q12_d   = acc_next[Q12_W-1:0];
          q12_v_d = 1'b1;
        end
        if (done_nx == 5'd8) begin
          q16_d   = acc_next[Q16_W-1:0];
          q16_v_d = 1'b1;
        end
        if (done_nx == 5'd16) begin
          q114_d   = acc_next;
          q114_v_d = 1'b1;
          dbz_d    = 1'b0;
        end
`endif
      end

      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q      <= '0;
      b_q      <= '0;
      nlo_q    <= '0;
      done_q   <= '0;
      acc_q    <= '0;
      q12_q    <= '0;
      q16_q    <= '0;
      q114_q   <= '0;
      q12_v_q  <= 1'b0;
      q16_v_q  <= 1'b0;
      q114_v_q <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      r_q      <= r_d;
      b_q      <= b_d;
      nlo_q    <= nlo_d;
      done_q   <= done_d;
      acc_q    <= acc_d;
      q12_q    <= q12_d;
      q16_q    <= q16_d;
      q114_q   <= q114_d;
      q12_v_q  <= q12_v_d;
      q16_v_q  <= q16_v_d;
      q114_v_q <= q114_v_d;
      dbz_q    <= dbz_d;
    end
  end

  assign q1_2_out    = q12_q;
  assign q1_2_valid  = q12_v_q;
  assign q1_6_out    = q16_q;
  assign q1_6_valid  = q16_v_q;
  assign q1_14_out   = q114_q;
  assign q1_14_valid = q114_v_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_progressive_div16.sv
// -----------------------------------------------------------------------------
// tb_progressive_div16
// Directed bench for progressive_div16: main instance with BITS_PER_CYCLE=1,
// plus B=2 and B=4 instances sharing the same inputs for latency checks.
// Build with PROGRESSIVE_DIV_ROUND_EN to get the rounded expectations.
// -----------------------------------------------------------------------------
module tb_progressive_div16;

`ifdef PROGRESSIVE_DIV_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / signals
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic        valid_in;

  logic        in_ready, q1_2_valid, q1_6_valid, q1_14_valid, div_by_zero;
  logic [3:0]  q1_2_out;
  logic [7:0]  q1_6_out;
  logic [15:0] q1_14_out;

  logic        rdy_2, v12_2, v16_2, v14_2, dbz_2;
  logic [3:0]  o12_2;
  logic [7:0]  o16_2;
  logic [15:0] o14_2;

  logic        rdy_4, v12_4, v16_4, v14_4, dbz_4;
  logic [3:0]  o12_4;
  logic [7:0]  o16_4;
  logic [15:0] o14_4;

  always #5 clk = ~clk;

  progressive_div16 #(.BITS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .valid_in(valid_in),
    .in_ready(in_ready),
    .q1_2_out(q1_2_out), .q1_2_valid(q1_2_valid),
    .q1_6_out(q1_6_out), .q1_6_valid(q1_6_valid),
    .q1_14_out(q1_14_out), .q1_14_valid(q1_14_valid),
    .div_by_zero(div_by_zero)
  );

  progressive_div16 #(.BITS_PER_CYCLE(2)) u_dut_b2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .valid_in(valid_in),
    .in_ready(rdy_2),
    .q1_2_out(o12_2), .q1_2_valid(v12_2),
    .q1_6_out(o16_2), .q1_6_valid(v16_2),
    .q1_14_out(o14_2), .q1_14_valid(v14_2),
    .div_by_zero(dbz_2)
  );

  progressive_div16 #(.BITS_PER_CYCLE(4)) u_dut_b4 (
    .clk(clk), .rst(rst), .a(a), .b(b), .valid_in(valid_in),
    .in_ready(rdy_4),
    .q1_2_out(o12_4), .q1_2_valid(v12_4),
    .q1_6_out(o16_4), .q1_6_valid(v16_4),
    .q1_14_out(o14_4), .q1_14_valid(v14_4),
    .div_by_zero(dbz_4)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: every q1_14 pulse of the main instance must match the next
  // expected quotient pushed by the driver.
  always @(negedge clk) begin
    if (q1_14_valid) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("sb_q14", 32'(q1_14_out), 32'(exp_q.pop_front()));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: one request, then watch pulse timing (cycle T+k) and values.
  // ---------------------------------------------------------------------------
  task automatic run_div(input string tag, input logic [15:0] a_v, b_v,
                         input logic [3:0] e12, input logic [7:0] e16,
                         input logic [15:0] e14, input logic e_dbz,
                         input int l12, l16, l14, input bit chk_fast);
    int k12 = 0, k16 = 0, k14 = 0, krdy = 0, k2 = 0, k4 = 0;
    logic [3:0]  v12 = '0;
    logic [7:0]  v16 = '0;
    logic [15:0] v14 = '0, w2 = '0, w4 = '0;
    logic        vdbz = 1'b0;

    @(negedge clk);
    check({tag, ".rdy_before"}, 32'(in_ready), 32'd1);
    a = a_v; b = b_v; valid_in = 1'b1;
    exp_q.push_back(e14);
    @(posedge clk); #1;
    valid_in = 1'b0;
    for (int k = 1; k <= l14 + 3; k++) begin
      if (q1_2_valid  && k12 == 0) begin k12 = k; v12 = q1_2_out; end
      if (q1_6_valid  && k16 == 0) begin k16 = k; v16 = q1_6_out; end
      if (q1_14_valid && k14 == 0) begin k14 = k; v14 = q1_14_out; vdbz = div_by_zero; end
      if (in_ready && krdy == 0) krdy = k;
      if (v14_2 && k2 == 0) begin k2 = k; w2 = o14_2; end
      if (v14_4 && k4 == 0) begin k4 = k; w4 = o14_4; end
      @(posedge clk); #1;
    end
    check({tag, ".lat12"}, 32'(k12), 32'(l12));
    check({tag, ".q12"},   32'(v12), 32'(e12));
    check({tag, ".lat16"}, 32'(k16), 32'(l16));
    check({tag, ".q16"},   32'(v16), 32'(e16));
    check({tag, ".lat14"}, 32'(k14), 32'(l14));
    check({tag, ".q14"},   32'(v14), 32'(e14));
    check({tag, ".dbz"},   32'(vdbz), 32'(e_dbz));
    check({tag, ".rdy_rise"}, 32'(krdy), 32'(l14));
    if (chk_fast) begin
      check({tag, ".b2_lat14"}, 32'(k2), 32'(9 + RND));
      check({tag, ".b2_q14"},   32'(w2), 32'(e14));
      check({tag, ".b4_lat14"}, 32'(k4), 32'(5 + RND));
      check({tag, ".b4_q14"},   32'(w4), 32'(e14));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int busy_hi;
    int k14;
    int n6, n14;
    logic [15:0] v14;

    rst = 1'b1; a = '0; b = '0; valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.valids", {28'd0, q1_2_valid, q1_6_valid, q1_14_valid, div_by_zero}, 32'd0);
    check("reset.data", {q1_2_out, q1_6_out, q1_14_out}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Iterating divisions: 1.0, 1/3, 2/3, 0, just-below-saturation.
    run_div("t1_one",   16'h4000, 16'h4000, 4'h4, 8'h40, 16'h4000, 1'b0, 5, 9, 17 + RND, 1'b1);
    run_div("t2_third", 16'h2000, 16'h6000, 4'h1, 8'h15, 16'h1555, 1'b0, 5, 9, 17 + RND, 1'b0);
    run_div("t3_2thrd", 16'h8000, 16'hC000, 4'h2, 8'h2A, (RND != 0) ? 16'h2AAB : 16'h2AAA,
            1'b0, 5, 9, 17 + RND, 1'b0);
    run_div("t6_zero",  16'h0000, 16'h4000, 4'h0, 8'h00, 16'h0000, 1'b0, 5, 9, 17 + RND, 1'b0);
    run_div("t7_max",   16'hFFFF, 16'h4000, 4'hF, 8'hFF, 16'hFFFF, 1'b0, 5, 9, 17 + RND, 1'b0);

    // Saturating requests: huge quotient, divide by zero, a == 4*b exactly.
    run_div("t4_sat",   16'hFFFF, 16'h0001, 4'hF, 8'hFF, 16'hFFFF, 1'b0, 1, 1, 1, 1'b0);
    run_div("t5_dbz",   16'h1234, 16'h0000, 4'hF, 8'hFF, 16'hFFFF, 1'b1, 1, 1, 1, 1'b0);
    run_div("t8_edge",  16'hC000, 16'h3000, 4'hF, 8'hFF, 16'hFFFF, 1'b0, 1, 1, 1, 1'b0);

    // valid_in held high with changing operands: only T and T+17(+RND) count.
    @(negedge clk);
    a = 16'h4000; b = 16'h4000; valid_in = 1'b1;
    exp_q.push_back(16'h4000);
    exp_q.push_back(16'h1555);
    @(posedge clk);
    busy_hi = 0;
    for (int k = 1; k <= 16 + RND; k++) begin
      @(negedge clk);
      a = 16'(k * 256); b = 16'h0800;
      if (in_ready) busy_hi++;
    end
    check("hold.busy_rdy_cycles", 32'(busy_hi), 32'd0);
    @(negedge clk);
    check("hold.rdy_again", 32'(in_ready), 32'd1);
    a = 16'h2000; b = 16'h6000;
    @(posedge clk); #1;
    valid_in = 1'b0;
    k14 = 0; v14 = '0;
    for (int k = 1; k <= 40; k++) begin
      if (q1_14_valid && k14 == 0) begin k14 = k; v14 = q1_14_out; end
      @(posedge clk); #1;
    end
    check("hold.lat14", 32'(k14), 32'(17 + RND));
    check("hold.q14", 32'(v14), 32'h1555);

    // Reset in the middle of a division (asserted during cycle T+6).
    @(negedge clk);
    a = 16'h4000; b = 16'h4000; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("midrst.in_ready", 32'(in_ready), 32'd1);
    check("midrst.valids", {28'd0, q1_2_valid, q1_6_valid, q1_14_valid, div_by_zero}, 32'd0);
    check("midrst.data", {q1_2_out, q1_6_out, q1_14_out}, 32'd0);
    @(negedge clk); rst = 1'b0;
    n6 = 0; n14 = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (q1_6_valid)  n6++;
      if (q1_14_valid) n14++;
    end
    check("midrst.q16_pulses", 32'(n6), 32'd0);
    check("midrst.q14_pulses", 32'(n14), 32'd0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
